// File: rtl/llmint8_pkg.sv
// llmint8_pkg: shared constants for the int8 dequantizer datapath.
// Build option DEQUANT_SATURATE_EN is consumed by dequant_lane.
package llmint8_pkg;

  localparam int SCALE_CONST = 127;
  localparam int RECIP_FRAC  = 16;
  localparam int RECIP       = 516;
  localparam int RECIP_W     = 11;

  function automatic int prod_width(input int a, input int b);
    return a + b;
  endfunction

  localparam int PROD_W = prod_width(8, 16);

endpackage

// File: rtl/dequant_lane.sv
// dequant_lane: per-element q*max_num, reciprocal scale, round, width rule.
// DEQUANT_SATURATE_EN clamps to the output range; otherwise low bits wrap.
module dequant_lane
  import llmint8_pkg::*;
#(
  parameter int IN_WIDTH      = 8,
  parameter int MAX_NUM_WIDTH = 16,
  parameter int OUT_WIDTH     = 16
) (
  input  logic signed [IN_WIDTH-1:0]               q,
  input  logic signed [MAX_NUM_WIDTH-1:0]          max_num,
  output logic signed [IN_WIDTH+MAX_NUM_WIDTH-1:0] prod,
  input  logic signed [IN_WIDTH+MAX_NUM_WIDTH-1:0] prod_in,
  output logic signed [OUT_WIDTH-1:0]              res
);

  localparam int PW = IN_WIDTH + MAX_NUM_WIDTH;
  localparam int TW = PW + RECIP_W;

  localparam logic signed [TW-1:0] RECIP_T = TW'(RECIP);
  localparam logic signed [TW-1:0] HALF    = TW'(1 << (RECIP_FRAC - 1));

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] r;

  assign prod = PW'(q) * PW'(max_num);

  assign t = TW'(prod_in) * RECIP_T;
  assign r = (t + HALF) >>> RECIP_FRAC;

`ifdef DEQUANT_SATURATE_EN
  localparam logic signed [OUT_WIDTH-1:0] OMAX =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OMIN =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    res = r[OUT_WIDTH-1:0];
    if (r > TW'(OMAX)) begin
      res = OMAX;
    end else if (r < TW'(OMIN)) begin
      res = OMIN;
    end
  end
`else
  logic unused_hi;

  // Two's-complement wrap: the upper bits are simply dropped.
  assign res       = r[OUT_WIDTH-1:0];
  assign unused_hi = ^r[TW-1:OUT_WIDTH];
`endif

endmodule

// File: rtl/dequantizer_part.sv
// dequantizer_part: 3-stage valid/ready int8 -> fixed-point dequantizer.
// Wrap vs clamp of the result is chosen by DEQUANT_SATURATE_EN.
module dequantizer_part
  import llmint8_pkg::*;
#(
  parameter int IN_WIDTH       = 8,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int MAX_NUM_WIDTH  = 16,
  parameter int OUT_WIDTH      = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]      data_in,
  input  logic [MAX_NUM_WIDTH-1:0]                        max_num_in,
  input  logic                                            data_in_valid,
  output logic                                            data_in_ready,
  output logic [OUT_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]     data_out,
  output logic [MAX_NUM_WIDTH-1:0]                        max_num_out,
  output logic                                            data_out_valid,
  input  logic                                            data_out_ready
);

  localparam int N  = IN_SIZE * IN_PARALLELISM;
  localparam int PW = IN_WIDTH + MAX_NUM_WIDTH;

  logic                       v1, v2, v3;
  logic                       ld1, ld2, ld3;
  logic [N*IN_WIDTH-1:0]      q1;
  logic [MAX_NUM_WIDTH-1:0]   m1, m2, m3;
  logic [N*PW-1:0]            p_nxt, p2;
  logic [N*OUT_WIDTH-1:0]     r_nxt, r3;

  // Each stage advances when empty or when its successor advances.
  assign ld3 = !v3 || data_out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;

  assign data_in_ready  = ld1;
  assign data_out       = r3;
  assign max_num_out    = m3;
  assign data_out_valid = v3;

  for (genvar i = 0; i < N; i++) begin : g_lane
    dequant_lane #(
      .IN_WIDTH      (IN_WIDTH),
      .MAX_NUM_WIDTH (MAX_NUM_WIDTH),
      .OUT_WIDTH     (OUT_WIDTH)
    ) u_lane (
      .q       (q1[i*IN_WIDTH +: IN_WIDTH]),
      .max_num (m1),
      .prod    (p_nxt[i*PW +: PW]),
      .prod_in (p2[i*PW +: PW]),
      .res     (r_nxt[i*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      q1 <= '0;
      m1 <= '0;
      p2 <= '0;
      m2 <= '0;
      r3 <= '0;
      m3 <= '0;
    end else begin
      if (ld1) begin
        v1 <= data_in_valid;
        q1 <= data_in;
        m1 <= max_num_in;
      end
      if (ld2) begin
        v2 <= v1;
        p2 <= p_nxt;
        m2 <= m1;
      end
      if (ld3) begin
        v3 <= v2;
        r3 <= r_nxt;
        m3 <= m2;
      end
    end
  end

endmodule

// File: tb/tb_dequantizer_part.sv
// tb_dequantizer_part: directed table, stall/reset sequences and a
// random streaming run checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_dequantizer_part;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [15:0] max_num_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [63:0] data_out;
  logic [15:0] max_num_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [15:0] m;
  } exp_t;

  typedef struct {
    logic [31:0] q;
    logic [15:0] m;
    logic [63:0] d;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  dequantizer_part dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .max_num_in     (max_num_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .max_num_out    (max_num_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] pk4(input int a, input int b,
                                      input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [63:0] pk16(input int a, input int b,
                                       input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [15:0] model(input logic [7:0] q,
                                        input logic [15:0] m);
    longint p;
    longint r;
    p = longint'($signed(q)) * longint'($signed(m));
    r = (p * 516 + 32768) >>> 16;
`ifdef DEQUANT_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [63:0] model_vec(input logic [31:0] d,
                                            input logic [15:0] m);
    logic [63:0] o;
    for (int i = 0; i < 4; i++) o[i*16 +: 16] = model(d[i*8 +: 8], m);
    return o;
  endfunction

  // Scoreboard: every beat leaving the DUT must match the oldest entry.
  always @(negedge clk) begin
    if (!rst && data_out_valid && data_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%h required=none", data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out", data_out, e.d);
        chk("max_num_out", {48'd0, max_num_out}, {48'd0, e.m});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [15:0] m,
                      input logic [63:0] want, output int stalls);
    exp_t e;
    data_in       = d;
    max_num_in    = m;
    data_in_valid = 1'b1;
    stalls        = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (data_in_ready) begin
        e.d = want;
        e.m = m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=stalled required=accept");
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [15:0] m);
    exp_t e;
    e.d = model_vec(d, m);
    e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_lat(input string nm, input int want);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (data_out_valid) begin
        seen = 1;
        lat  = i;
      end
    end
    chk(nm, 64'(lat), 64'(want));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          st;
    int          tot;
    int          acc;
    bit          have;
    bit          done;
    logic [63:0] held_d;
    logic [15:0] held_m;
    logic [31:0] b3d[4];
    logic [15:0] b3m[4];
    int          ovf_a;
    int          ovf_b;

`ifdef DEQUANT_SATURATE_EN
    ovf_a = -32768;
    ovf_b = 32767;
`else
    ovf_a = 32513;
    ovf_b = -32512;
`endif
    vecs[0] = '{pk4(127, -127, 64, 0), 16'd1000,
                pk16(1000, -1000, 504, 0)};
    vecs[1] = '{pk4(-128, 127, 1, -1), 16'd32767,
                pk16(ovf_a, 32765, 258, -258)};
    vecs[2] = '{pk4(10, -10, 100, -100), 16'd127,
                pk16(10, -10, 100, -100)};
    vecs[3] = '{pk4(127, -127, 64, 0), 16'(-1000),
                pk16(-1000, 1000, -504, 0)};
    vecs[4] = '{pk4(5, 6, 7, 8), 16'd0,
                pk16(0, 0, 0, 0)};
    vecs[5] = '{pk4(-128, 1, 127, 0), 16'h8000,
                pk16(ovf_b, -258, -32766, 0)};

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_max", 64'(max_num_out), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(data_in_ready), 64'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      send(vecs[i].q, vecs[i].m, vecs[i].d, st);
      data_in_valid = 1'b0;
      wait_lat("latency", 3);
      drain();
      @(posedge clk);
      #1;
    end

    tot = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] d;
          logic [15:0] m;
          d = pk4(i * 16 - 60, -i, i + 1, 3 * i);
          m = 16'(200 + i * 37);
          send(d, m, model_vec(d, m), st);
          tot += st;
        end
        data_in_valid = 1'b0;
      end
      begin
        int run;
        bit seen;
        seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
          @(negedge clk);
          if (data_out_valid) seen = 1;
        end
        run = seen ? 1 : 0;
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          if (data_out_valid) run++;
        end
        chk("b2b_contiguous", 64'(run), 64'd8);
      end
    join
    chk("b2b_stalls", 64'(tot), 64'd0);
    drain();

    for (int i = 0; i < 4; i++) begin
      b3d[i] = pk4(20 * i - 100, 90 - i, -7 * i, i);
      b3m[i] = 16'(3000 + 111 * i);
    end
    @(posedge clk);
    #1;
    data_out_ready = 1'b0;
    acc            = 0;
    have           = 0;
    held_d         = '0;
    held_m         = '0;
    data_in        = b3d[0];
    max_num_in     = b3m[0];
    data_in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (data_out_valid) begin
        if (!have) begin
          held_d = data_out;
          held_m = max_num_out;
          have   = 1;
        end else begin
          chk("stall_hold_data", data_out, held_d);
          chk("stall_hold_max", 64'(max_num_out), 64'(held_m));
        end
      end
      if (data_in_ready && acc < 4) begin
        push_exp(b3d[acc], b3m[acc]);
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc < 4) begin
        data_in    = b3d[acc];
        max_num_in = b3m[acc];
      end
    end
    chk("stall_accepts", 64'(acc), 64'd3);
    @(negedge clk);
    chk("stall_full_ready", 64'(data_in_ready), 64'd0);
    chk("stall_hold_last", data_out, held_d);
    @(posedge clk);
    #1 data_out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'(data_in_ready), 64'd1);
    push_exp(b3d[3], b3m[3]);
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    drain();

    @(posedge clk);
    #1 data_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] d;
      d = pk4(i + 1, -i - 1, 50, -50);
      send(d, 16'd500, model_vec(d, 16'd500), st);
    end
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(data_out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(data_out_valid), 64'd0);
    chk("rst_async_data", data_out, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    data_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_stale_beat", 64'(data_out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(vecs[2].q, vecs[2].m, vecs[2].d, st);
    data_in_valid = 1'b0;
    wait_lat("post_rst_latency", 3);
    drain();

    @(posedge clk);
    #1;
    done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [31:0] d;
          logic [15:0] m;
          d = $urandom;
          m = 16'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            data_in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(d, m, model_vec(d, m), st);
        end
        data_in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 data_out_ready = ($urandom_range(0, 3) != 0);
        end
        data_out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
